// File: rtl/gcd_pkg.sv
// gcd_pkg: state encoding and datapath select codes shared by the GCD engine.
package gcd_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
   localparam logic [1:0] ASEL_IN   = 2'd0;
   localparam logic [1:0] ASEL_B    = 2'd1;
   localparam logic [1:0] ASEL_SUB  = 2'd2;
   localparam logic [1:0] ASEL_HOLD = 2'd3;
   localparam logic       BSEL_IN   = 1'b0;
   localparam logic       BSEL_A    = 1'b1;
endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: A/B registers with select muxes, subtractor and status comparators.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       a_sel_i,
   input  logic             a_en_i,
   input  logic             b_sel_i,
   input  logic             b_en_i,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   output logic [WIDTH-1:0] a_o,
   output logic             a_lt_b_o,
   output logic             b_eq_0_o
);
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   always_comb begin
      a_d = a_sel_i == ASEL_IN  ? in_a_i :
            a_sel_i == ASEL_B   ? b_q :
            a_sel_i == ASEL_SUB ? a_q - b_q : a_q;
      b_d = b_sel_i == BSEL_IN ? in_b_i : a_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (a_en_i) a_q <= a_d;
         if (b_en_i) b_q <= b_d;
      end
   end
   assign a_o      = a_q;
   assign a_lt_b_o = a_q < b_q;
   assign b_eq_0_o = b_q == '0;
endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: subtract-and-swap GCD engine with valid/ready handshakes.
// Optional GCD_CYCLE_COUNT_EN adds a 'cycles' output counting CALC cycles per operation.
module gcd_unit
   import gcd_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             a_lt_b,
   output logic             b_eq_0
`ifdef GCD_CYCLE_COUNT_EN
   ,
   output logic [CNT_W-1:0] cycles
`endif
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d, a_val;
   logic [1:0]       a_sel;
   logic             b_sel, a_en, b_en, accept;
   gcd_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .a_sel_i  (a_sel),
      .a_en_i   (a_en),
      .b_sel_i  (b_sel),
      .b_en_i   (b_en),
      .in_a_i   (in_a),
      .in_b_i   (in_b),
      .a_o      (a_val),
      .a_lt_b_o (a_lt_b),
      .b_eq_0_o (b_eq_0)
   );
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result    = result_q;
   assign accept    = in_valid && in_ready;
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      a_sel    = ASEL_HOLD;
      b_sel    = BSEL_IN;
      a_en     = 1'b0;
      b_en     = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            a_sel   = ASEL_IN;
            a_en    = 1'b1;
            b_en    = 1'b1;
            state_d = CALC;
         end
         CALC: if (a_lt_b) begin
            a_sel = ASEL_B;
            b_sel = BSEL_A;
            a_en  = 1'b1;
            b_en  = 1'b1;
         end else if (!b_eq_0) begin
            a_sel = ASEL_SUB;
            a_en  = 1'b1;
         end else begin
            result_d = a_val;
            state_d  = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end
`ifdef GCD_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d  = accept ? '0 : state_q == CALC ? cnt_q + CNT_W'(1) : cnt_q;
   assign cycles = cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif
endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed and random checks of gcd_unit against a Euclid-based reference.
module tb_gcd_unit;
   localparam int W  = 5;
   localparam int CW = W + 1;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ready, out_valid, a_lt_b, b_eq_0;
   logic [W-1:0] result;
   int           checks = 0;
   int           errors = 0;
`ifdef GCD_CYCLE_COUNT_EN
   logic [CW-1:0] cycles;
`endif
   gcd_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .a_lt_b    (a_lt_b),
      .b_eq_0    (b_eq_0)
`ifdef GCD_CYCLE_COUNT_EN
      ,
      .cycles    (cycles)
`endif
   );
   always #5 clk = ~clk;
   function automatic int ref_gcd(int a, int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction
   // One count per subtract or swap step, plus the cycle that observes B==0.
   function automatic int ref_cycles(int a, int b);
      int n = 1;
      int t;
      while (!(a >= b && b == 0)) begin
         if (a < b) begin
            t = a;
            a = b;
            b = t;
         end else a = a - b;
         n++;
      end
      return n;
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(string tag, int obs, int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic issue(int a, int b);
      check("accept_ready", int'(in_ready), 1);
      in_a = W'(a);
      in_b = W'(b);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         step();
         lat++;
      end
      if (!out_valid) check("timeout", 0, 1);
   endtask
   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("drain_valid", int'(out_valid), 0);
      check("drain_ready", int'(in_ready), 1);
   endtask
   task automatic txn(int a, int b, string tag);
      int lat;
      issue(a, b);
      wait_done(lat);
      check({tag, "_result"}, int'(result), ref_gcd(a, b));
      check({tag, "_latency"}, lat, ref_cycles(a, b));
`ifdef GCD_CYCLE_COUNT_EN
      check({tag, "_cycles"}, int'(cycles), ref_cycles(a, b));
`endif
      drain();
   endtask
   initial begin
      int lat;
      int held;
      step();
      step();
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_result", int'(result), 0);
      check("rst_a_lt_b", int'(a_lt_b), 0);
      check("rst_b_eq_0", int'(b_eq_0), 1);
      rst = 1'b0;
      step();
      // (6,3) with a visible A/B trace via the status flags, operands changed mid-CALC
      issue(6, 3);
      in_a = 5'd17;
      in_b = 5'd4;
      check("t63_lt0", int'(a_lt_b), 0);
      check("t63_bz0", int'(b_eq_0), 0);
      step();
      check("t63_lt1", int'(a_lt_b), 0);
      step();
      check("t63_lt2", int'(a_lt_b), 1);
      step();
      check("t63_lt3", int'(a_lt_b), 0);
      check("t63_bz3", int'(b_eq_0), 1);
      check("t63_not_done", int'(out_valid), 0);
      step();
      check("t63_valid", int'(out_valid), 1);
      check("t63_result", int'(result), 3);
`ifdef GCD_CYCLE_COUNT_EN
      check("t63_cycles", int'(cycles), 4);
`endif
      // backpressure with in_valid pending in DONE
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_valid", int'(out_valid), 1);
         check("bp_result", int'(result), 3);
         check("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release_valid", int'(out_valid), 0);
      check("bp_release_ready", int'(in_ready), 1);
      in_valid = 1'b0;
      step();
      check("bp_no_accept", int'(in_ready), 1);
      txn(0, 0, "g00");
      txn(0, 7, "g07");
      txn(12, 0, "g120");
      txn(31, 1, "g311");
      txn(21, 14, "g2114");
      check("g311_ref", ref_cycles(31, 1), 33);
      // reset mid-CALC
      issue(31, 1);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_ready", int'(in_ready), 1);
      check("midrst_result", int'(result), 0);
      check("midrst_b_eq_0", int'(b_eq_0), 1);
`ifdef GCD_CYCLE_COUNT_EN
      check("midrst_cycles", int'(cycles), 0);
`endif
      txn(9, 6, "g96");
      for (int i = 0; i < 40; i++) begin
         int a = int'($urandom_range(0, (1 << W) - 1));
         int b = int'($urandom_range(0, (1 << W) - 1));
         txn(a, b, "rand");
      end
      held = 0;
      issue(20, 8);
      wait_done(lat);
      while (held < 3) begin
         step();
         held++;
      end
      check("hold_result", int'(result), 4);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
- Parametrised GCD engine: the next generation of the 5-bit A/B subtract-and-swap datapath.
- Adds an internal control FSM plus valid/ready handshakes on input and output.
- Sits between an operand producer and a result consumer.
- Computes gcd(a,b) by repeated subtraction and swap; latency depends on the data.

Parameters:
- WIDTH, 5, operand/result width in bits (>=2).
- CNT_W, WIDTH+1, width of the cycle counter; covers the worst case of 2^WIDTH+1 compute cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands on in_a/in_b are valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  gcd value.
- a_lt_b  out  1  status: A register < B register (debug).
- b_eq_0  out  1  status: B register == 0 (debug).

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst; all state changes on the rising edge of clk.
- Reset state: state=IDLE, A=0, B=0, out_valid=0, result=0, in_ready=1 from the first edge with rst=1. a_lt_b=0 and b_eq_0=1 follow from A=B=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: A<=in_a, B<=in_b, go to CALC. Otherwise hold.
  - CALC: in_ready=0. One action per cycle, in priority order:
    (1) if A<B: swap (A<=B, B<=A);
    (2) else if B!=0: A<=A-B (unsigned, never underflows since A>=B);
    (3) else (B==0): go to DONE with registered result<=A.
  - DONE: out_valid=1, result stable. On out_ready, go to IDLE with out_valid<=0. No accept in the same cycle: in_ready stays 0 in DONE.
- Datapath select encoding, held in the shared package:
  - A mux: 0=in_a, 1=B, 2=A-B, 3=hold.
  - B mux: 0=in_b, 1=A.
  - Separate load enables for A and B.
- a_lt_b and b_eq_0 are combinational from the A/B registers.
- Boundary cases:
  - gcd(0,0)=0, 1 CALC cycle.
  - gcd(0,x)=x: swap, then done, 2 CALC cycles.
  - gcd(x,0)=x, 1 CALC cycle.
  - Max inputs (2^W-1, 1): 2^W+1 CALC cycles.
- Input operands are sampled only on the accept edge. Later in_a/in_b changes are ignored until the next IDLE.
- out_ready low in DONE: hold result and out_valid indefinitely.
- rst asserted in any state, including mid-CALC or in DONE: next edge forces the reset state; the in-flight result is discarded.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- Defined:
  - Extra output port cycles [CNT_W-1:0].
  - Counter clears to 0 on accept and increments on every CALC cycle, including the terminating one.
  - Value holds through DONE and IDLE until the next accept; reset value 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package gcd_pkg holds:
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - A mux select codes (ASEL_IN, ASEL_B, ASEL_SUB, ASEL_HOLD);
  - B mux select codes (BSEL_IN, BSEL_A).
- Sub-module gcd_datapath(WIDTH):
  - contains the A/B registers, both muxes, the subtractor and the comparators;
  - inputs: selects and enables; outputs: A value, a_lt_b, b_eq_0.
- gcd_unit contains the FSM, handshake logic, result register and optional counter.

Test Plan:
- Reset, then accept (6,3):
  - CALC sequence A/B = 3/3, 0/3, 3/0, then done;
  - out_valid rises 4 cycles after the accept edge; result=3; cycles=4.
- (0,0) -> result=0, cycles=1. (0,7) -> result=7, cycles=2. (12,0) -> result=12, cycles=1.
- WIDTH=5, (31,1) -> result=1, cycles=33, out_valid at accept+33. (21,14) -> result=7.
- Backpressure:
  - hold out_ready=0 for 10 cycles after out_valid: result stable, in_ready=0;
  - then out_ready=1 for 1 cycle: out_valid=0 and in_ready=1 on the next cycle.
- Assert rst for 1 cycle mid-CALC of (31,1): next cycle state IDLE, out_valid=0, in_ready=1; a new (9,6) then yields 3.
- Change in_a/in_b during CALC of (6,3): result still 3. in_valid held high in DONE: no accept until back in IDLE.
